// File: rtl/weighted_round_robin_arbiter.sv
// Weighted round-robin arbiter: registered one-hot grant held for weight_i beats, zero-bubble handover.
// Optional packet lock (define WRR_LOCK_EN) adds lock_i to hold ownership past the last credit.
module weighted_round_robin_arbiter #(
   parameter int NUM_REQ  = 4,
   parameter int WEIGHT_W = 4,
   parameter int IDX_W    = $clog2(NUM_REQ)
) (
   input  logic                         clk_i,
   input  logic                         arst_ni,
   input  logic                         allow_i,
   input  logic [NUM_REQ-1:0]           req_i,
   input  logic [NUM_REQ*WEIGHT_W-1:0]  weight_i,
   input  logic                         ack_i,
`ifdef WRR_LOCK_EN
   input  logic                         lock_i,
`endif
   output logic [NUM_REQ-1:0]           gnt_o,
   output logic                         gnt_valid_o,
   output logic [IDX_W-1:0]             gnt_idx_o,
   output logic [WEIGHT_W-1:0]          credit_o
);

   typedef enum logic {IDLE = 1'b0, OWN = 1'b1} state_e;

   state_e                state_q;
   logic [NUM_REQ-1:0]    gnt_q;
   logic [IDX_W-1:0]      idx_q;
   logic [IDX_W-1:0]      ptr_q;
   logic [WEIGHT_W-1:0]   credit_q;

   logic [IDX_W-1:0]      owner_nxt;
   logic [IDX_W-1:0]      scan_start;
   logic [IDX_W-1:0]      cand;
   logic [IDX_W-1:0]      win_idx;
   logic                  win_found;
   logic [NUM_REQ-1:0]    win_oh;
   logic [WEIGHT_W-1:0]   win_weight;
   logic [WEIGHT_W-1:0]   load_credit;
   logic                  lock_hold;
   logic                  release_now;

   function automatic logic [IDX_W-1:0] inc_mod(input logic [IDX_W-1:0] i);
      if (i == IDX_W'(NUM_REQ - 1)) return '0;
      return i + IDX_W'(1);
   endfunction

`ifdef WRR_LOCK_EN
   assign lock_hold = lock_i;
`else
   assign lock_hold = 1'b0;
`endif

   assign owner_nxt   = inc_mod(idx_q);
   // On release the search already starts past the owner, so it only wins again when alone.
   assign scan_start  = (state_q == OWN) ? owner_nxt : ptr_q;
   assign release_now = (state_q == OWN) &&
                        (!req_i[idx_q] || (ack_i && credit_q == WEIGHT_W'(1) && !lock_hold));

   always_comb begin
      win_idx   = '0;
      win_found = 1'b0;
      cand      = scan_start;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (!win_found && req_i[cand]) begin
            win_found = 1'b1;
            win_idx   = cand;
         end
         cand = inc_mod(cand);
      end
      win_oh          = '0;
      win_oh[win_idx] = 1'b1;
      win_weight      = weight_i[win_idx*WEIGHT_W +: WEIGHT_W];
      load_credit     = (win_weight == '0) ? WEIGHT_W'(1) : win_weight;
   end

   always_ff @(posedge clk_i or negedge arst_ni) begin
      if (!arst_ni) begin
         state_q  <= IDLE;
         gnt_q    <= '0;
         idx_q    <= '0;
         ptr_q    <= '0;
         credit_q <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (allow_i && win_found) begin
                  state_q  <= OWN;
                  gnt_q    <= win_oh;
                  idx_q    <= win_idx;
                  credit_q <= load_credit;
               end
            end
            OWN: begin
               if (release_now) begin
                  ptr_q <= owner_nxt;
                  if (allow_i && win_found) begin
                     gnt_q    <= win_oh;
                     idx_q    <= win_idx;
                     credit_q <= load_credit;
                  end else begin
                     state_q  <= IDLE;
                     gnt_q    <= '0;
                     credit_q <= '0;
                  end
               end else if (ack_i && credit_q > WEIGHT_W'(1)) begin
                  credit_q <= credit_q - WEIGHT_W'(1);
               end
            end
         endcase
      end
   end

   assign gnt_o       = gnt_q;
   assign gnt_valid_o = |gnt_q;
   assign gnt_idx_o   = idx_q;
   assign credit_o    = credit_q;

endmodule

// File: tb/tb_weighted_round_robin_arbiter.sv
// Directed bench for the weighted round-robin arbiter: a 4-requester and a 3-requester instance.
module tb_weighted_round_robin_arbiter;

   logic        clk = 1'b0;
   logic        arst_n = 1'b0;

   logic        allow4 = 1'b0;
   logic [3:0]  req4 = '0;
   logic [15:0] wt4 = '0;
   logic        ack4 = 1'b0;
   logic [3:0]  gnt4;
   logic        vld4;
   logic [1:0]  idx4;
   logic [3:0]  cred4;
`ifdef WRR_LOCK_EN
   logic        lock4 = 1'b0;
`endif

   logic        allow3 = 1'b0;
   logic [2:0]  req3 = '0;
   logic [11:0] wt3 = '0;
   logic        ack3 = 1'b0;
   logic [2:0]  gnt3;
   logic        vld3;
   logic [1:0]  idx3;
   logic [3:0]  cred3;

   int checks = 0;
   int failures = 0;

   always #5 clk = ~clk;

   weighted_round_robin_arbiter #(.NUM_REQ(4), .WEIGHT_W(4)) u4 (
      .clk_i(clk), .arst_ni(arst_n), .allow_i(allow4), .req_i(req4), .weight_i(wt4), .ack_i(ack4),
`ifdef WRR_LOCK_EN
      .lock_i(lock4),
`endif
      .gnt_o(gnt4), .gnt_valid_o(vld4), .gnt_idx_o(idx4), .credit_o(cred4)
   );

   weighted_round_robin_arbiter #(.NUM_REQ(3), .WEIGHT_W(4)) u3 (
      .clk_i(clk), .arst_ni(arst_n), .allow_i(allow3), .req_i(req3), .weight_i(wt3), .ack_i(ack3),
`ifdef WRR_LOCK_EN
      .lock_i(1'b0),
`endif
      .gnt_o(gnt3), .gnt_valid_o(vld3), .gnt_idx_o(idx3), .credit_o(cred3)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic enter_reset();
      arst_n = 1'b0;
      tick();
      tick();
   endtask

   task automatic check4(input string name, input logic [3:0] eg, input logic [1:0] ei,
                         input logic [3:0] ec);
      checks++;
      if (gnt4 !== eg || idx4 !== ei || cred4 !== ec || vld4 !== (|eg)) begin
         failures++;
         $display("FAIL %s: gnt=%b idx=%0d credit=%0d valid=%b, expected gnt=%b idx=%0d credit=%0d",
                  name, gnt4, idx4, cred4, vld4, eg, ei, ec);
      end
   endtask

   task automatic test_reset();
      int exp_idx[9] = '{0, 0, 1, 1, 2, 2, 3, 3, 0};
      int exp_cr[9]  = '{2, 1, 2, 1, 2, 1, 2, 1, 2};
      logic [3:0] one = 4'b0001;
      enter_reset();
      wt4 = {4'd2, 4'd2, 4'd2, 4'd2};
      req4 = 4'b1111; allow4 = 1'b1; ack4 = 1'b1;
      tick();
      check4("reset_held", 4'b0000, 2'd0, 4'd0);
      arst_n = 1'b1;
      for (int i = 0; i < 9; i++) begin
         tick();
         check4($sformatf("rr_w2_beat%0d", i), one << exp_idx[i], 2'(exp_idx[i]), 4'(exp_cr[i]));
      end
   endtask

   task automatic test_weights();
      int exp_idx[8] = '{0, 0, 0, 1, 2, 3, 3, 0};
      int exp_cr[8]  = '{3, 2, 1, 1, 1, 2, 1, 3};
      logic [3:0] one = 4'b0001;
      enter_reset();
      wt4 = {4'd2, 4'd0, 4'd1, 4'd3};
      req4 = 4'b1111; allow4 = 1'b1; ack4 = 1'b1;
      arst_n = 1'b1;
      for (int i = 0; i < 8; i++) begin
         tick();
         check4($sformatf("weights_beat%0d", i), one << exp_idx[i], 2'(exp_idx[i]), 4'(exp_cr[i]));
      end
   endtask

   task automatic test_req_drop();
      enter_reset();
      wt4 = {4'd3, 4'd3, 4'd3, 4'd3};
      req4 = 4'b0010; allow4 = 1'b1; ack4 = 1'b0;
      arst_n = 1'b1;
      tick();
      check4("drop_grant1", 4'b0010, 2'd1, 4'd3);
      req4 = 4'b0110; ack4 = 1'b1;
      tick();
      check4("drop_ack1", 4'b0010, 2'd1, 4'd2);
      req4 = 4'b0100; ack4 = 1'b0;
      tick();
      check4("drop_handover", 4'b0100, 2'd2, 4'd3);
      req4 = 4'b0000; ack4 = 1'b1;
      tick();
      check4("drop_to_idle_idx_hold", 4'b0000, 2'd2, 4'd0);
   endtask

   task automatic test_allow();
      enter_reset();
      wt4 = {4'd2, 4'd2, 4'd2, 4'd2};
      req4 = 4'b0101; allow4 = 1'b0; ack4 = 1'b0;
      arst_n = 1'b1;
      tick();
      tick();
      check4("allow_low_idle", 4'b0000, 2'd0, 4'd0);
      allow4 = 1'b1;
      tick();
      check4("allow_grant0", 4'b0001, 2'd0, 4'd2);
      allow4 = 1'b0; ack4 = 1'b1;
      tick();
      check4("allow_low_burst", 4'b0001, 2'd0, 4'd1);
      tick();
      check4("allow_low_release", 4'b0000, 2'd0, 4'd0);
      tick();
      check4("allow_low_wait", 4'b0000, 2'd0, 4'd0);
      allow4 = 1'b1;
      tick();
      check4("allow_resume_ptr", 4'b0100, 2'd2, 4'd2);
   endtask

   task automatic test_sole_wrap3();
      enter_reset();
      allow4 = 1'b0; req4 = '0; ack4 = 1'b0;
      wt3 = {4'd1, 4'd1, 4'd1};
      req3 = 3'b100; allow3 = 1'b1; ack3 = 1'b1;
      arst_n = 1'b1;
      for (int i = 0; i < 4; i++) begin
         tick();
         checks++;
         if (gnt3 !== 3'b100 || idx3 !== 2'd2 || cred3 !== 4'd1 || vld3 !== 1'b1) begin
            failures++;
            $display("FAIL n3_sole_beat%0d: gnt=%b idx=%0d credit=%0d valid=%b, expected 100/2/1/1",
                     i, gnt3, idx3, cred3, vld3);
         end
      end
      req3 = 3'b111;
      tick();
      checks++;
      if (gnt3 !== 3'b001 || idx3 !== 2'd0) begin
         failures++;
         $display("FAIL n3_wrap: gnt=%b idx=%0d, expected gnt=001 idx=0", gnt3, idx3);
      end
      tick();
      checks++;
      if (gnt3 !== 3'b010 || idx3 !== 2'd1) begin
         failures++;
         $display("FAIL n3_next: gnt=%b idx=%0d, expected gnt=010 idx=1", gnt3, idx3);
      end
      req3 = '0; allow3 = 1'b0; ack3 = 1'b0;
   endtask

`ifdef WRR_LOCK_EN
   task automatic test_lock();
      enter_reset();
      wt4 = {4'd1, 4'd1, 4'd1, 4'd1};
      req4 = 4'b0011; allow4 = 1'b1; ack4 = 1'b0; lock4 = 1'b0;
      arst_n = 1'b1;
      tick();
      check4("lock_grant0", 4'b0001, 2'd0, 4'd1);
      ack4 = 1'b1; lock4 = 1'b1;
      for (int i = 0; i < 4; i++) begin
         tick();
         check4($sformatf("lock_hold%0d", i), 4'b0001, 2'd0, 4'd1);
      end
      lock4 = 1'b0;
      tick();
      check4("lock_release", 4'b0010, 2'd1, 4'd1);
      lock4 = 1'b1; req4 = 4'b0001;
      tick();
      check4("lock_req_drop", 4'b0001, 2'd0, 4'd1);
      lock4 = 1'b0;
   endtask
`endif

   initial begin
      test_reset();
      test_weights();
      test_req_drop();
      test_allow();
      test_sole_wrap3();
`ifdef WRR_LOCK_EN
      test_lock();
`endif
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/weighted_round_robin_arbiter.md
Name: weighted_round_robin_arbiter

Overview:
- Successor to the single-cycle round-robin arbiter. It adds per-requester programmable weights (burst credits), registered and held grants with an ack-based beat handshake, and zero-bubble handover between owners.
- Sits in front of shared buses and shared execution resources, where one requester must own the resource for a multi-beat transfer.
- Fairness is cyclic: after an owner releases, search restarts at owner+1.

Parameters:
- NUM_REQ, 4, number of requesters (>=2).
- WEIGHT_W, 4, width of each per-requester weight and of the credit counter.
- IDX_W, $clog2(NUM_REQ), width of the grant index (derived; do not override).

Ports:
- clk_i  input  1  clock
- arst_ni  input  1  asynchronous reset, active low
- allow_i  input  1  permits new grants; does not affect an existing owner
- req_i  input  NUM_REQ  request per requester; must stay high while the requester wants ownership
- weight_i  input  NUM_REQ*WEIGHT_W  beats per grant; requester k uses bits [k*WEIGHT_W +: WEIGHT_W]
- ack_i  input  1  one beat accepted by the current owner this cycle
- gnt_o  output  NUM_REQ  registered one-hot grant
- gnt_valid_o  output  1  equals |gnt_o
- gnt_idx_o  output  IDX_W  index of the owner; holds its last value when no grant is active
- credit_o  output  WEIGHT_W  beats remaining for the current owner

Behaviour:
- Reset: arst_ni low asynchronously clears gnt_o, gnt_valid_o, gnt_idx_o, credit_o and the rotation pointer (ptr) to 0, and sets state IDLE. While in reset, req_i is ignored.
- States: IDLE (no owner) and OWN (owner held in gnt_o).
- Winner select (combinational): the first k with req_i[k] high, scanning ptr, ptr+1, ... mod NUM_REQ.
- Weights: sampled when a grant is issued. Credit is loaded with weight_i[winner]; a weight of 0 is treated as 1. Weight changes during ownership have no effect until the next grant.
- IDLE -> OWN: requires allow_i and |req_i. At the clock edge, gnt_o = onehot(winner), gnt_idx_o = winner and credit is loaded. Latency from req to grant is exactly 1 cycle.
- OWN, ack_i with credit > 1: credit decrements by 1 and ownership is held.
- OWN, release condition: (ack_i and credit == 1) or req_i[owner] low.
  - On release, ptr = (owner+1) mod NUM_REQ.
  - In the same cycle, a new winner is selected using the updated ptr.
  - If allow_i is high and some request is pending, the next edge issues the new grant, so there are zero idle cycles between owners.
  - Otherwise gnt_o = 0 and the state goes to IDLE.
  - The releasing owner is eligible only if no other requester is pending.
- Back-to-back same owner: possible only when it is the sole requester. Credit is then reloaded from the current weight.
- ack_i outside OWN: ignored. ack_i in the same cycle as req_i[owner] falling: release, no error.
- allow_i low during OWN: the owner continues to completion. At release, the block goes to IDLE and waits for allow_i.
- credit_o: 0 in IDLE; otherwise the remaining beats, including the current beat.
- gnt_o is always one-hot or zero and never changes except at a release or at a new grant.
- Width rules:
  - ptr and idx arithmetic are modulo NUM_REQ, including for non-power-of-2 NUM_REQ (e.g. 3 or 5).
  - The credit counter never underflows.
  - The maximum burst is 2^WEIGHT_W - 1 beats.

Optional Feature:
- Macro WRR_LOCK_EN adds input port lock_i (1 bit).
- With the macro: when ack_i and credit == 1 and lock_i is high, ownership is held and credit stays at 1. This gives packet lock: the owner keeps the grant until a beat with lock_i low, or until it drops req_i.
- With the macro, release on req_i[owner] low still applies regardless of lock_i.
- Without the macro: the lock_i port does not exist, and credit exhaustion always releases.

Test Plan:
- Reset, weights all 2, req_i=4'b1111, ack_i held high: grants go 0,0,1,1,2,2,3,3,0. gnt_o and credit_o are 0 during reset, and the first grant appears 1 cycle after reset release.
- Weights {3,1,0,2} for reqs 0..3, all requesting, ack high: the grant sequence per beat is 0,0,0,1,2,3,3,0. Weight 0 behaves as 1.
- Owner 1, credit 3, req_i[1] dropped after 1 ack, req_i[2] pending: the next edge grants 2 with gnt_idx_o=2 and no idle cycle.
- allow_i=0 with req_i=4'b0101 in IDLE: no grant. Raising allow_i gives gnt_o=4'b0001 one cycle later. Dropping allow_i mid-burst lets the burst finish, then the block goes to IDLE.
- NUM_REQ=3, sole requester 2, weight 1, ack high: gnt_o stays 3'b100 continuously, credit is reloaded each beat and ptr wraps to 0.
- With WRR_LOCK_EN: weight 1, lock_i high for 4 acks, then low: the owner is held for 5 beats, then the grant rotates.
